// File: rtl/booth_mul_sched.sv
// booth_mul_sched: round-robin scheduler sharing one fixed-latency Booth multiplier
// between two requesters, with a held response and rsp_ready backpressure.
module booth_mul_sched #(
    parameter int N   = 25,
    parameter int LAT = N + 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0_valid,
    input  logic [N-1:0]   req0_m,
    input  logic [N-1:0]   req0_q,
    output logic           req0_ready,
    input  logic           req1_valid,
    input  logic [N-1:0]   req1_m,
    input  logic [N-1:0]   req1_q,
    output logic           req1_ready,
    output logic           mul_start,
    output logic [N-1:0]   mul_m,
    output logic [N-1:0]   mul_q,
    input  logic [2*N-1:0] mul_result,
    output logic           rsp_valid,
    output logic           rsp_id,
    output logic [2*N-1:0] rsp_result,
    input  logic           rsp_ready
);
    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;
    localparam int CW = $clog2(LAT + 1);
    localparam logic [CW-1:0] LAST = CW'(LAT - 1);
    state_t state, state_nx;
    logic ptr;
    logic [CW-1:0] cnt;
    logic gnt0, gnt1;
    // ptr holds the last granted index, so a tie goes to the other one
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        state_nx = state;
        case (state)
            IDLE: begin
                gnt0 = req0_valid && (!req1_valid || ptr);
                gnt1 = req1_valid && !gnt0;
                state_nx = (gnt0 || gnt1) ? START : IDLE;
            end
            START: state_nx = WAIT;
            WAIT: state_nx = (cnt == LAST) ? DONE : WAIT;
            DONE: state_nx = rsp_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end
    assign req0_ready = rst_n && gnt0;
    assign req1_ready = rst_n && gnt1;
    assign mul_start = state == START;
    assign rsp_valid = state == DONE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr <= 1'b1;
            cnt <= '0;
            rsp_id <= 1'b0;
            mul_m <= '0;
            mul_q <= '0;
            rsp_result <= '0;
        end else begin
            state <= state_nx;
            if (gnt0 || gnt1) begin
                ptr <= gnt1;
                rsp_id <= gnt1;
                mul_m <= gnt1 ? req1_m : req0_m;
                mul_q <= gnt1 ? req1_q : req0_q;
            end
            if (state == START)
                cnt <= '0;
            else if (state == WAIT && cnt != LAST)
                cnt <= cnt + 1'b1;
            if (state == WAIT && cnt == LAST)
                rsp_result <= mul_result;
        end
    end
endmodule

// File: tb/tb_booth_mul_sched.sv
// tb_booth_mul_sched: directed bench with a latency-exact multiplier model and a
// response scoreboard filled at each observed grant.
module tb_booth_mul_sched;
    localparam int N = 25;
    localparam int LAT = N + 4;
    localparam int W2 = 2 * N;
    typedef struct packed {
        logic id;
        logic [W2-1:0] res;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b1;
    logic [N-1:0] req0_m = '0, req0_q = '0, req1_m = '0, req1_q = '0;
    logic req0_ready, req1_ready, mul_start, rsp_valid, rsp_id;
    logic [N-1:0] mul_m, mul_q;
    logic [W2-1:0] mul_result, rsp_result, mp = '0;
    int mk = 1000;
    exp_t sb[$];
    logic glog[$];
    logic ptr_m = 1'b1;
    int checks = 0, errors = 0, gcnt = 0, scnt = 0, rcnt = 0;

    booth_mul_sched #(.N(N), .LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_m(req0_m), .req0_q(req0_q), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_m(req1_m), .req1_q(req1_q), .req1_ready(req1_ready),
        .mul_start(mul_start), .mul_m(mul_m), .mul_q(mul_q), .mul_result(mul_result),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_ready(rsp_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [W2-1:0] prod(input logic signed [N-1:0] a, input logic signed [N-1:0] b);
        logic signed [W2-1:0] r;
        r = a * b;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [W2-1:0] got, input logic [W2-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // The product is only correct in the one cycle before the capture edge.
    always @(posedge clk) begin
        if (mul_start) begin
            mp <= prod(mul_m, mul_q);
            mk <= 0;
        end else if (mk < 1000) mk <= mk + 1;
    end
    assign mul_result = (mk == LAT - 1) ? mp : ~mp;

    always @(negedge clk) begin
        logic w;
        exp_t e;
        if (!rst_n) begin
            ptr_m = 1'b1;
            sb.delete();
        end else begin
            if (mul_start) scnt++;
            if (req0_ready || req1_ready) begin
                w = (req0_valid && req1_valid) ? !ptr_m : req1_valid;
                chk("grant_id", W2'(req1_ready), W2'(w));
                chk("one_grant", W2'(req0_ready & req1_ready), W2'(0));
                chk("ready_wo_valid", W2'((req0_ready & ~req0_valid) | (req1_ready & ~req1_valid)), W2'(0));
                ptr_m = w;
                gcnt++;
                glog.push_back(w);
                sb.push_back('{w, w ? prod(req1_m, req1_q) : prod(req0_m, req0_q)});
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) chk("extra_rsp", W2'(rsp_valid), W2'(0));
                else begin
                    e = sb.pop_front();
                    chk("rsp_id", W2'(rsp_id), W2'(e.id));
                    chk("rsp_result", rsp_result, e.res);
                    rcnt++;
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_start"}, W2'(mul_start), W2'(0));
        chk({tag, "_rsp_valid"}, W2'(rsp_valid), W2'(0));
        chk({tag, "_ready0"}, W2'(req0_ready), W2'(0));
        chk({tag, "_ready1"}, W2'(req1_ready), W2'(0));
        chk({tag, "_rsp_id"}, W2'(rsp_id), W2'(0));
        chk({tag, "_mul_m"}, W2'(mul_m), W2'(0));
        chk({tag, "_mul_q"}, W2'(mul_q), W2'(0));
        chk({tag, "_rsp_result"}, rsp_result, W2'(0));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(3);
        rst_n = 1'b1;
    endtask

    task automatic wait_grant(input int target);
        for (int i = 0; i < 300 && gcnt < target; i++) cyc(1);
        chk("grant_wait", W2'(gcnt), W2'(target));
    endtask

    task automatic wait_rsp();
        for (int i = 0; i < 200 && !rsp_valid; i++) cyc(1);
        chk("rsp_wait", W2'(rsp_valid), W2'(1));
    endtask

    task automatic op(input logic id, input logic [N-1:0] m, input logic [N-1:0] q, input logic [W2-1:0] exp);
        int n;
        if (id) begin req1_m = m; req1_q = q; req1_valid = 1'b1; end
        else begin req0_m = m; req0_q = q; req0_valid = 1'b1; end
        wait_grant(gcnt + 1);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (rsp_valid) break;
        end
        chk("latency", W2'(n), W2'(LAT + 1));
        chk("op_id", W2'(rsp_id), W2'(id));
        chk("op_result", rsp_result, exp);
        cyc(1);
        chk("op_drained", W2'(sb.size()), W2'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int g, s, r, seen;
        logic [N-1:0] mn, mx;
        logic [W2-1:0] e;
        req0_valid = 1'b1;
        #2;
        chk_zero("reset");
        req0_valid = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        s = scnt;
        op(1'b0, N'(3), N'(5), W2'(15));
        chk("single_starts", W2'(scnt - s), W2'(1));
        do_reset();
        g = gcnt;
        req0_m = N'(2); req0_q = N'(7); req1_m = -N'(4); req1_q = N'(6);
        req0_valid = 1'b1; req1_valid = 1'b1;
        wait_grant(g + 4);
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int i = 0; i < 300 && sb.size() != 0; i++) cyc(1);
        chk("tie_drain", W2'(sb.size()), W2'(0));
        for (int k = 0; k < 4; k++)
            if (glog.size() > g + k) chk("tie_order", W2'(glog[g + k]), W2'(k % 2));
        chk("tie_log", W2'(glog.size() - g), W2'(4));
        rsp_ready = 1'b0;
        req0_m = N'(123); req0_q = -N'(45); req0_valid = 1'b1;
        wait_grant(gcnt + 1);
        req0_valid = 1'b0;
        req1_m = N'(7); req1_q = N'(7); req1_valid = 1'b1;
        wait_rsp();
        s = scnt;
        for (int i = 0; i < 20; i++) begin
            chk("bp_valid", W2'(rsp_valid), W2'(1));
            chk("bp_id", W2'(rsp_id), W2'(0));
            chk("bp_result", rsp_result, prod(N'(123), -N'(45)));
            chk("bp_ready1", W2'(req1_ready), W2'(0));
            cyc(1);
        end
        chk("bp_starts", W2'(scnt - s), W2'(0));
        rsp_ready = 1'b1;
        wait_grant(gcnt + 1);
        req1_valid = 1'b0;
        for (int i = 0; i < 300 && sb.size() != 0; i++) cyc(1);
        chk("bp_drain", W2'(sb.size()), W2'(0));
        cyc(2);
        req0_m = N'(9); req0_q = N'(9); req0_valid = 1'b1;
        wait_grant(gcnt + 1);
        req0_valid = 1'b0;
        cyc(11);
        rst_n = 1'b0;
        #1;
        chk_zero("midwait");
        cyc(2);
        rst_n = 1'b1;
        r = rcnt;
        seen = 0;
        for (int i = 0; i < LAT + 5; i++) begin
            seen |= int'(rsp_valid);
            cyc(1);
        end
        chk("stale_rsp", W2'(seen), W2'(0));
        chk("stale_count", W2'(rcnt - r), W2'(0));
        op(1'b1, '1, '1, W2'(1));
        mn = {1'b1, {(N-1){1'b0}}};
        mx = {1'b0, {(N-1){1'b1}}};
        op(1'b0, mn, mn, W2'(1) << (W2 - 2));
        e = W2'(0) - W2'(mx);
        op(1'b1, mx, '1, e);
        op(1'b0, '0, '0, W2'(0));
        g = gcnt; r = rcnt;
        rsp_ready = 1'b0;
        req0_m = N'(5); req0_q = N'(6); req0_valid = 1'b1;
        wait_grant(g + 1);
        req0_valid = 1'b0;
        req1_m = N'(11); req1_q = N'(13);
        req1_valid = 1'b1; cyc(1); req1_valid = 1'b0;
        cyc(5);
        req1_valid = 1'b1; cyc(1); req1_valid = 1'b0;
        wait_rsp();
        req1_valid = 1'b1; cyc(2); req1_valid = 1'b0;
        cyc(1);
        rsp_ready = 1'b1;
        cyc(LAT + 6);
        chk("drop_grants", W2'(gcnt - g), W2'(1));
        chk("drop_rsps", W2'(rcnt - r), W2'(1));
        chk("drop_drain", W2'(sb.size()), W2'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/booth_mul_sched.md
BOOTH_MUL_SCHED -- requirements
Module: booth_mul_sched

Interface
REQ-001: Parameter N, default 25, sets the operand width in bits of each requester and of the shared Booth multiplier.
REQ-002: Parameter LAT, default N+4 (29), sets the cycles from the mul_start cycle to the cycle mul_result is sampled.
REQ-003: The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows.
REQ-004: clk  input  1  rising-edge clock.
REQ-005: rst_n  input  1  asynchronous reset, active low.
REQ-006: req0_valid, req1_valid  input  1 each  requester n has an operand pair pending.
REQ-007: req0_m, req0_q, req1_m, req1_q  input  N each  two's-complement multiplicand and multiplier.
REQ-008: req0_ready, req1_ready  output  1 each  request accepted this cycle.
REQ-009: mul_start  output  1  one-cycle start pulse to the shared multiplier.
REQ-010: mul_m, mul_q  output  N each  operands driven to the multiplier.
REQ-011: mul_result  input  2N  multiplier product.
REQ-012: rsp_valid  output  1  response available.
REQ-013: rsp_id  output  1  index of the requester that owns the response.
REQ-014: rsp_result  output  2N  captured product.
REQ-015: rsp_ready  input  1  consumer accepts the response.

Function
REQ-016: The FSM SHALL have four states: IDLE, START, WAIT and DONE.
REQ-017: In IDLE, a grant SHALL occur when any req valid is high: it sets reqX_ready=1 combinationally for the winner only, latches that requester's m/q into mul_m/mul_q, records the id, and moves to START.
REQ-018: Arbitration SHALL be round-robin with a 1-bit last-grant pointer: with both valid, grant the index not granted last; with one valid, grant it regardless of the pointer; update the pointer on every grant.
REQ-019: reqX_ready SHALL be 0 in every state except IDLE, and 0 for a non-winner.
REQ-020: In START, mul_start SHALL be 1 for exactly this cycle; clear the cycle counter to 0; go to WAIT.
REQ-021: In WAIT, the counter SHALL increment each cycle; when it reaches LAT-1, capture mul_result into rsp_result and go to DONE.
REQ-022: The capture edge SHALL be exactly LAT cycles after the mul_start edge.
REQ-023: The counter SHALL be wide enough for LAT-1 without wrap, and SHALL saturate rather than wrap.
REQ-024: mul_m and mul_q SHALL hold stable from the grant cycle until the next grant.
REQ-025: In DONE, rsp_valid SHALL be 1, with rsp_id and rsp_result held stable until rsp_ready=1.
REQ-026: The rsp_valid && rsp_ready handshake SHALL return the FSM to IDLE.
REQ-027: With backpressure (rsp_ready low), the FSM SHALL stay in DONE indefinitely, no new grant SHALL occur, and no mul_start SHALL be issued.
REQ-028: A new grant SHALL be allowed at the earliest in the cycle after the handshake, giving a minimum issue interval of LAT+3 cycles per operation.
REQ-029: A request deasserted before its grant SHALL be dropped silently, with no state change.
REQ-030: req inputs SHALL be ignored outside IDLE.
REQ-031: rsp_result SHALL be the raw 2N-bit product with no sign or width alteration.
REQ-032: A 0x0 operand pair SHALL be treated as any other; there SHALL be no fast path.

Reset
REQ-033: rst_n low SHALL take effect immediately, independent of clk.
REQ-034: Under reset, the FSM SHALL be IDLE, the pointer SHALL be 1 (so port 0 wins the first tie), the counter 0, and mul_start, rsp_valid, reqX_ready, rsp_id, mul_m, mul_q and rsp_result all 0.
REQ-035: Reset asserted mid-WAIT or mid-DONE SHALL abort the operation: no response is emitted, and the in-flight product is discarded.
REQ-036: After rst_n deasserts, the first grant SHALL be possible on the first rising edge.

Verification
REQ-037: Single request: req0 m=3, q=5, rsp_ready=1 -> one mul_start pulse; rsp_valid exactly LAT+1 cycles after the grant with rsp_id=0 and rsp_result=15 (model product).
REQ-038: Tie: both valid continuously after reset, operands (2,7) and (-4,6) -> grant order 0,1,0,1; results 14, -24 (sign-extended to 2N bits) and alternating ids.
REQ-039: Backpressure: rsp_ready=0 for 20 cycles in DONE -> rsp_valid, rsp_id and rsp_result stay constant; no mul_start; req1_ready stays 0 throughout.
REQ-040: Reset mid-WAIT: pull rst_n low at counter=10 -> all outputs 0 at once; after release, no stale rsp_valid; a fresh req1 (-1,-1) -> rsp_result=1.
REQ-041: Boundary operands: m=q=-2^(N-1) -> rsp_result=2^(2N-2); m=2^(N-1)-1, q=-1 -> rsp_result=-(2^(N-1)-1).
REQ-042: A valid pulse dropped in START, WAIT or DONE -> never granted, no extra response.
